// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if
// Handshake bundle between the round-robin scheduler, its input FIFOs
// (pop / empty / read data) and the shared output FIFO (push / data /
// almost-full). The master side is the scheduler, the slave side the FIFOs.

interface fifo_rr_arbiter_if #(
    parameter int DATA_WIDTH = 10,
    parameter int N_REQ      = 4
);

    logic [N_REQ-1:0]            empty_in;
    logic [N_REQ*DATA_WIDTH-1:0] data_in;
    logic [N_REQ-1:0]            pop_out;
    logic                        out_almost_full;
    logic                        push_out;
    logic [DATA_WIDTH-1:0]       data_out;

    modport master (
        input  empty_in,
        input  data_in,
        input  out_almost_full,
        output pop_out,
        output push_out,
        output data_out
    );

    modport slave (
        output empty_in,
        output data_in,
        output out_almost_full,
        input  pop_out,
        input  push_out,
        input  data_out
    );

endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
// Round-robin scheduler draining N_REQ input FIFOs into one output FIFO.
// A registered one-hot pop selects a lane; RD_LAT cycles later that lane's
// word is on data_in and is registered into data_out together with push_out.
// Lanes popped within the last RD_LAT cycles are masked so that a lane whose
// empty flag has not caught up yet is never popped past its last word.
// New pops stop while the output FIFO is almost full; words already in
// flight are still pushed.
// Optional feature: define FIFO_ARB_STATS_EN to add the grant_cnt port with
// one 8-bit saturating pop counter per lane.

module fifo_rr_arbiter #(
    parameter int DATA_WIDTH = 10,
    parameter int N_REQ      = 4,
    parameter int RD_LAT     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [2:0]               alto_in,
    input  logic [2:0]               bajo_in,
    output logic [2:0]               alto_cfg,
    output logic [2:0]               bajo_cfg,
    fifo_rr_arbiter_if.master        fifo_bus,
    output logic [2:0]               grant_idx,
    output logic [1:0]               state_out,
    output logic                     idle
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*8-1:0]       grant_cnt
`endif
);

    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

    // One-hot decode of a lane index.
    function automatic logic [N_REQ-1:0] lane_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec = {N_REQ{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (idx == IDX_W'(k)) begin
                vec[k] = 1'b1;
            end else begin
                vec[k] = 1'b0;
            end
        end
        return vec;
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic                    idle_r;
    logic [IDX_W-1:0]        ptr_r;
    logic [N_REQ-1:0]        pop_r;
    logic [IDX_W-1:0]        grant_idx_r;
    logic [RD_LAT-1:0]       pipe_vld_r;
    logic [IDX_W-1:0]        pipe_idx_r [RD_LAT];
    logic                    push_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [2:0]              alto_r;
    logic [2:0]              bajo_r;

    logic [N_REQ-1:0]        recent_s;
    logic [N_REQ-1:0]        eligible_s;
    logic                    any_s;
    logic                    found_s;
    logic [IDX_W-1:0]        sel_s;
    logic                    grant_s;
    logic [DATA_WIDTH-1:0]   lane_data_s;

    // Lanes popped this cycle or in the previous RD_LAT-1 cycles.
    always_comb begin
        recent_s = pop_r;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (pipe_vld_r[i] && (pipe_idx_r[i] == IDX_W'(k))) begin
                    recent_s[k] = 1'b1;
                end else begin
                    recent_s[k] = recent_s[k];
                end
            end
        end
    end

    assign eligible_s = ~fifo_bus.empty_in & ~recent_s;
    assign any_s      = |eligible_s;

    // Round-robin search: first eligible lane at or after the pointer.
    always_comb begin
        int cand_v;
        found_s = 1'b0;
        sel_s   = {IDX_W{1'b0}};
        cand_v  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_v = int'(ptr_r) + i;
            if (cand_v >= N_REQ) begin
                cand_v = cand_v - N_REQ;
            end else begin
                cand_v = cand_v;
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (!found_s && (cand_v == k) && eligible_s[k]) begin
                    found_s = 1'b1;
                    sel_s   = IDX_W'(k);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // A grant is issued from IDLE or ACTIVE only, never while configuring or stalled.
    always_comb begin
        grant_s = 1'b0;
        if (((state_r == ST_IDLE) || (state_r == ST_ACTIVE)) && !init
            && !fifo_bus.out_almost_full && found_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state logic; init overrides every state.
    always_comb begin
        state_s = state_r;
        if (init) begin
            state_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    state_s = ST_IDLE;
                end
                ST_IDLE: begin
                    if (any_s && !fifo_bus.out_almost_full) begin
                        state_s = ST_ACTIVE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (fifo_bus.out_almost_full) begin
                        state_s = ST_STALL;
                    end else if (!any_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ACTIVE;
                    end
                end
                ST_STALL: begin
                    if (fifo_bus.out_almost_full) begin
                        state_s = ST_STALL;
                    end else if (any_s) begin
                        state_s = ST_ACTIVE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_INIT;
                end
            endcase
        end
    end

    // Read data of the lane whose pop reaches the end of the read pipeline.
    always_comb begin
        lane_data_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (pipe_idx_r[RD_LAT-1] == IDX_W'(k)) begin
                lane_data_s = fifo_bus.data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                lane_data_s = lane_data_s;
            end
        end
    end

    // State register and registered idle flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_INIT;
            idle_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idle_r  <= (state_s == ST_IDLE);
        end
    end

    // Pop, grant index and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_r       <= {N_REQ{1'b0}};
            grant_idx_r <= {IDX_W{1'b0}};
            ptr_r       <= {IDX_W{1'b0}};
        end else if (grant_s) begin
            pop_r       <= lane_onehot(sel_s);
            grant_idx_r <= sel_s;
            if (sel_s == IDX_W'(N_REQ - 1)) begin
                ptr_r <= {IDX_W{1'b0}};
            end else begin
                ptr_r <= sel_s + IDX_W'(1);
            end
        end else begin
            pop_r       <= {N_REQ{1'b0}};
            grant_idx_r <= {IDX_W{1'b0}};
            ptr_r       <= ptr_r;
        end
    end

    // In-flight read pipeline: {valid, lane} delayed by RD_LAT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_idx_r[i] <= {IDX_W{1'b0}};
            end
        end else begin
            pipe_vld_r[0] <= |pop_r;
            pipe_idx_r[0] <= grant_idx_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_idx_r[i] <= pipe_idx_r[i-1];
            end
        end
    end

    // Output FIFO push and registered data word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_r <= 1'b0;
            data_r <= {DATA_WIDTH{1'b0}};
        end else if (pipe_vld_r[RD_LAT-1]) begin
            push_r <= 1'b1;
            data_r <= lane_data_s;
        end else begin
            push_r <= 1'b0;
            data_r <= data_r;
        end
    end

    // Threshold capture while in the configuration state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alto_r <= 3'd0;
            bajo_r <= 3'd0;
        end else if (state_r == ST_INIT) begin
            alto_r <= alto_in;
            bajo_r <= bajo_in;
        end else begin
            alto_r <= alto_r;
            bajo_r <= bajo_r;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [7:0] cnt_r [N_REQ];

    // Per-lane saturating pop counters, cleared on entry to INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                cnt_r[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if ((state_s == ST_INIT) && (state_r != ST_INIT)) begin
                    cnt_r[k] <= 8'd0;
                end else if (pop_r[k] && (cnt_r[k] != 8'hFF)) begin
                    cnt_r[k] <= cnt_r[k] + 8'd1;
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
        end
    end

    // Flatten the counters onto the statistics port.
    always_comb begin
        grant_cnt = {(N_REQ*8){1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            grant_cnt[k*8 +: 8] = cnt_r[k];
        end
    end
`endif

    assign fifo_bus.pop_out  = pop_r;
    assign fifo_bus.push_out = push_r;
    assign fifo_bus.data_out = data_r;
    assign grant_idx         = grant_idx_r;
    assign state_out         = state_r;
    assign idle              = idle_r;
    assign alto_cfg          = alto_r;
    assign bajo_cfg          = bajo_r;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter
// Bench for fifo_rr_arbiter: behavioural input-FIFO environment, a
// rule-level scheduler model checked every cycle, and directed scenarios
// with literal expectations. Define FIFO_ARB_STATS_EN to include counters.

module tb_fifo_rr_arbiter;

    localparam int DW  = 10;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        init;
    logic [2:0]  alto_in;
    logic [2:0]  bajo_in;
    logic [2:0]  alto_cfg;
    logic [2:0]  bajo_cfg;
    logic [2:0]  grant_idx;
    logic [1:0]  state_out;
    logic        idle;
`ifdef FIFO_ARB_STATS_EN
    logic [N*8-1:0] grant_cnt;
`endif

    fifo_rr_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(N)) bus ();

    fifo_rr_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .RD_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .alto_in   (alto_in),
        .bajo_in   (bajo_in),
        .alto_cfg  (alto_cfg),
        .bajo_cfg  (bajo_cfg),
        .fifo_bus  (bus),
        .grant_idx (grant_idx),
        .state_out (state_out),
        .idle      (idle)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // environment: input FIFO contents and read-latency delay
    int q [N][$];
    int dly [N];
    int data_reg [N];
    // logs of what the DUT did, for directed checks
    int pop_lane_log [$];
    int pop_cyc_log [$];
    int push_log [$];

    // model state
    int m_state, m_ptr, m_alto, m_bajo, exp_pop;
    int hist [$];
    int mq [N][$];
    int sb_due [$];
    int sb_word [$];
    int m_cnt [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        logic [N*DW-1:0] dv;
        logic [N-1:0]    ev;
        for (int k = 0; k < N; k++) begin
            ev[k] = (q[k].size() == 0);
            dv[k*DW +: DW] = data_reg[k][DW-1:0];
        end
        bus.empty_in = ev;
        bus.data_in  = dv;
    endtask

    task automatic load(input int k, input int w);
        q[k].push_back(w);
        mq[k].push_back(w);
        refresh();
    endtask

    task automatic tick();
        logic [N-1:0] p;
        p = bus.pop_out;
        for (int k = 0; k < N; k++) begin
            if (p[k]) begin
                pop_lane_log.push_back(k);
                pop_cyc_log.push_back(cyc);
            end
        end
        if (bus.push_out) push_log.push_back(int'(bus.data_out));
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            data_reg[k] = dly[k];
            if (p[k] && q[k].size() > 0) dly[k] = q[k].pop_front();
        end
        refresh();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        pop_lane_log.delete();
        pop_cyc_log.delete();
        push_log.delete();
    endtask

    // Rule-level model: compares every cycle, then predicts the next one.
    always @(negedge clk) begin
        int exp_vec, ns, nxt;
        bit exp_push, elig, any, masked, grant;
        cyc++;
        if (reset) begin
            chk("rst_pop", bus.pop_out, 0);
            chk("rst_push", bus.push_out, 0);
            chk("rst_data", bus.data_out, 0);
            chk("rst_gidx", grant_idx, 0);
            chk("rst_state", state_out, 0);
            chk("rst_idle", idle, 0);
            chk("rst_alto", alto_cfg, 0);
            chk("rst_bajo", bajo_cfg, 0);
            m_state = 0; m_ptr = 0; m_alto = 0; m_bajo = 0; exp_pop = -1;
            hist.delete(); sb_due.delete(); sb_word.delete();
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
        end else begin
            exp_vec = (exp_pop >= 0) ? (1 << exp_pop) : 0;
            chk("pop_out", bus.pop_out, exp_vec);
            chk("grant_idx", grant_idx, (exp_pop >= 0) ? exp_pop : 0);
            exp_push = (sb_due.size() > 0) && (sb_due[0] == cyc);
            chk("push_out", bus.push_out, exp_push);
            if (exp_push) begin
                chk("data_out", bus.data_out, sb_word[0]);
                void'(sb_due.pop_front());
                void'(sb_word.pop_front());
            end
            chk("state_out", state_out, m_state);
            chk("idle", idle, m_state == 1);
            chk("alto_cfg", alto_cfg, m_alto);
            chk("bajo_cfg", bajo_cfg, m_bajo);
`ifdef FIFO_ARB_STATS_EN
            for (int k = 0; k < N; k++) chk("grant_cnt", grant_cnt[k*8 +: 8], m_cnt[k]);
`endif
            if (exp_pop >= 0) begin
                sb_due.push_back(cyc + LAT + 1);
                sb_word.push_back(mq[exp_pop].size() > 0 ? mq[exp_pop].pop_front() : -1);
                if (m_cnt[exp_pop] < 255) m_cnt[exp_pop]++;
            end
            hist.push_front(exp_pop);
            while (hist.size() > LAT) void'(hist.pop_back());
            any = 0;
            nxt = -1;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                masked = 0;
                foreach (hist[j]) if (hist[j] == k) masked = 1;
                elig = !bus.empty_in[k] && !masked;
                if (elig && nxt < 0) nxt = k;
                any = any | elig;
            end
            grant = !init && !bus.out_almost_full && (m_state == 1 || m_state == 2) && (nxt >= 0);
            if (m_state == 0) begin
                m_alto = alto_in;
                m_bajo = bajo_in;
            end
            if (init) ns = 0;
            else if (m_state == 0) ns = 1;
            else if (m_state == 1) ns = (any && !bus.out_almost_full) ? 2 : 1;
            else if (m_state == 2) ns = bus.out_almost_full ? 3 : (any ? 2 : 1);
            else ns = bus.out_almost_full ? 3 : (any ? 2 : 1);
            if (ns == 0 && m_state != 0) for (int k = 0; k < N; k++) m_cnt[k] = 0;
            exp_pop = grant ? nxt : -1;
            if (grant) m_ptr = (nxt + 1) % N;
            m_state = ns;
        end
    end

    initial begin
        int zp;
        reset = 1'b1;
        init = 1'b1;
        alto_in = 3'd6;
        bajo_in = 3'd1;
        bus.out_almost_full = 1'b0;
        for (int k = 0; k < N; k++) begin
            dly[k] = 0;
            data_reg[k] = 0;
        end
        refresh();
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // T1: configuration capture, then leave INIT
        chk("t1_alto", alto_cfg, 6);
        chk("t1_bajo", bajo_cfg, 1);
        chk("t1_pop", bus.pop_out, 0);
        init = 1'b0;
        tick();
        chk("t1_state", state_out, 1);
        chk("t1_idle", idle, 1);
        alto_in = 3'd2;
        bajo_in = 3'd5;
        tick(); tick();
        chk("t1_alto_held", alto_cfg, 6);

        // T2: four lanes, three words each
        clear_logs();
        for (int k = 0; k < N; k++)
            for (int n = 0; n < 3; n++) load(k, (2 << 6) | (k << 4) | n);
        run(25);
        chk("t2_npop", pop_lane_log.size(), 12);
        for (int i = 0; i < 12 && i < pop_lane_log.size(); i++) chk("t2_lane", pop_lane_log[i], i % 4);
        chk("t2_npush", push_log.size(), 12);
        if (push_log.size() >= 2) begin
            chk("t2_word0", push_log[0], 128);
            chk("t2_word1", push_log[1], 144);
        end else begin
            chk("t2_words_present", push_log.size(), 2);
        end
        chk("t2_state", state_out, 1);

        // T3: single lane, masked between pops
        clear_logs();
        for (int n = 0; n < 3; n++) load(2, (3 << 6) | (2 << 4) | n);
        run(20);
        chk("t3_npop", pop_lane_log.size(), 3);
        for (int i = 0; i < pop_lane_log.size(); i++) chk("t3_lane", pop_lane_log[i], 2);
        if (pop_cyc_log.size() == 3) begin
            chk("t3_gap1", pop_cyc_log[1] - pop_cyc_log[0], 3);
            chk("t3_gap2", pop_cyc_log[2] - pop_cyc_log[1], 3);
        end else begin
            chk("t3_gaps_present", pop_cyc_log.size(), 3);
        end
        chk("t3_npush", push_log.size(), 3);
        chk("t3_idle", idle, 1);

        // T4: backpressure while streaming
        clear_logs();
        for (int k = 0; k < N; k++)
            for (int n = 0; n < 6; n++) load(k, (4 << 6) | (k << 4) | n);
        run(6);
        bus.out_almost_full = 1'b1;
        zp = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) chk("t4_stall", state_out, 3);
            if (i == 5) bus.out_almost_full = 1'b0;
            zp = zp | int'(bus.pop_out);
        end
        chk("t4_no_pops", zp, 0);
        tick();
        chk("t4_resume_lane", bus.pop_out, 4'b0010);
        run(40);
        chk("t4_npush", push_log.size(), 24);

        // T5: reset with words in flight
        clear_logs();
        for (int k = 0; k < N; k++)
            for (int n = 0; n < 4; n++) load(k, (5 << 6) | (k << 4) | n);
        run(5);
        chk("t5_push_before", bus.push_out, 1);
        reset = 1'b1;
        #1;
        chk("t5_pop_now", bus.pop_out, 0);
        chk("t5_push_now", bus.push_out, 0);
        tick(); tick();
        reset = 1'b0;
        clear_logs();
        run(3);
        chk("t5_no_push", push_log.size(), 0);
        run(40);
        chk("t5_alto_recfg", alto_cfg, 2);

`ifdef FIFO_ARB_STATS_EN
        // T6: counter saturation and clear on INIT entry
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        clear_logs();
        for (int n = 0; n < 300; n++) load(0, n);
        run(920);
        chk("t6_npop", pop_lane_log.size(), 300);
        chk("t6_cnt0", grant_cnt[7:0], 255);
        chk("t6_cnt1", grant_cnt[15:8], 0);
        chk("t6_cnt2", grant_cnt[23:16], 0);
        chk("t6_cnt3", grant_cnt[31:24], 0);
        init = 1'b1;
        tick(); tick();
        chk("t6_cleared", grant_cnt, 0);
        init = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
